match_scheduler: RTL and testbench
==================================

Name: match_scheduler

Overview:
Sequences the vocabulary matcher over a batch of input words held in the input SRAM. For each word it resets the matcher, points it at the word's start address, runs it until done or timeout, and streams one result per word over a valid/ready interface. It sits between the top-level control (start/busy/done) and one matcher instance plus its vocab/input SRAMs.

Parameters:
ADDR_WIDTH, 4, SRAM address width; matches the matcher.
MAX_WORDS, 8, maximum words per batch; word_count width is $clog2(MAX_WORDS+1).
TIMEOUT_CYCLES, 64, max cycles in RUN per word before abort; counter width is $clog2(TIMEOUT_CYCLES+1).

Ports:
clk  in  1  clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  batch start request; sampled only in IDLE.
word_count  in  $clog2(MAX_WORDS+1)  number of words in the batch; captured on start.
word_base_addr  in  ADDR_WIDTH  input SRAM address of word 0; captured on start.
word_stride  in  ADDR_WIDTH  address step between words; captured on start.
m_rst_n  out  1  active-low reset to the matcher.
m_cs  out  1  matcher chip select / run enable.
m_input_start_addr  out  ADDR_WIDTH  start address of the current word for the matcher.
m_found  in  1  matcher found flag.
m_done  in  1  matcher done flag.
m_vocab_addr  in  ADDR_WIDTH  matcher's current vocab address (addr_v).
res_valid  out  1  result available.
res_ready  in  1  consumer accepts result.
res_word_idx  out  $clog2(MAX_WORDS)  index of the word within the batch.
res_found  out  1  word matched a vocab entry.
res_vocab_addr  out  ADDR_WIDTH  m_vocab_addr captured when done is seen; 0 if not found.
res_timeout  out  1  word aborted by timeout.
found_count  out  $clog2(MAX_WORDS+1)  running count of found words in the current/last batch.
busy  out  1  high from the cycle after start until FINISH.
done  out  1  single-cycle pulse at batch end.

Behaviour:
- Reset values: m_rst_n=0, m_cs=0, m_input_start_addr=0, res_valid=0, res_word_idx=0, res_found=0, res_vocab_addr=0, res_timeout=0, found_count=0, busy=0, done=0. State is IDLE.
- States: IDLE, CLEAR, RUN, EMIT, FINISH.
- IDLE: m_rst_n=1, m_cs=0.
  - If start=1 and word_count!=0: capture count, base and stride; idx=0; found_count=0; m_input_start_addr=base; go to CLEAR.
  - If start=1 and word_count==0: go to FINISH directly. No results are produced and found_count is cleared.
- CLEAR: exactly 1 cycle with m_rst_n=0 and m_cs=0. Timeout counter is cleared. Go to RUN.
- RUN: m_rst_n=1, m_cs=1, with m_input_start_addr held stable. The timeout counter increments each cycle.
  - If m_done=1: latch res_found=m_found and res_timeout=0. Latch res_vocab_addr=m_vocab_addr if m_found, else 0. found_count increments if m_found. Go to EMIT.
  - Else if the counter reaches TIMEOUT_CYCLES: latch res_found=0, res_timeout=1, res_vocab_addr=0. Go to EMIT.
  - If m_done and the timeout occur in the same cycle, m_done wins.
- EMIT: m_cs=0. res_valid=1 and all res_* outputs are held stable until res_valid&res_ready.
  - On transfer: res_valid=0 next cycle.
  - If idx==count-1, go to FINISH.
  - Otherwise idx++, m_input_start_addr += word_stride (mod 2^ADDR_WIDTH, wraps silently), and go to CLEAR.
- FINISH: done=1 for one cycle, busy=0 next cycle, then IDLE. found_count holds until the next accepted start.
- busy=1 in CLEAR/RUN/EMIT, and in FINISH too; it drops together with the done pulse ending.
- start while busy is ignored; it is not queued.
- Batch latency with no backpressure and matcher done after D cycles in RUN: per word 1 (CLEAR) + D + 1 (EMIT); plus 1 FINISH cycle.
- rst asserted at any point, including mid-RUN or mid-EMIT: all outputs return to reset values on the next edge, the batch is abandoned, and no done pulse is issued.
- word_count > MAX_WORDS is clamped to MAX_WORDS at capture.

Test Plan:
- Reset/idle: assert rst 2 cycles -> all outputs at reset values, m_rst_n=0 during reset, busy=0 after. Then start with word_count=0 -> done pulses 1 cycle, res_valid never 1, found_count=0.
- Single word found: base=0, count=1, matcher model raises m_done+m_found with m_vocab_addr=4'h5 after 6 RUN cycles, res_ready=1 -> one result {idx=0, found=1, vocab_addr=5, timeout=0}, found_count=1, done 1 cycle after the transfer.
- Batch with stride and wrap: base=4'hC, stride=4, count=3 -> m_input_start_addr sequence C,0,4. m_rst_n low exactly 1 cycle before each RUN. Three results with idx 0,1,2.
- Backpressure: res_ready held 0 for 5 cycles in EMIT -> res_valid stays 1 and res_* stable; m_cs=0 throughout; next CLEAR begins the cycle after the handshake.
- Timeout and tie: matcher never asserts done -> result found=0, timeout=1 after exactly TIMEOUT_CYCLES RUN cycles. Separately, m_done=1 on the timeout cycle -> timeout=0.
- Reset mid-batch and ignored start: rst during RUN of word 1 of 3 -> outputs reset, no done pulse. Then start pulses while busy in a new batch -> batch unaffected, result count = word_count.

Source files
------------

// File: rtl/match_scheduler.sv
// match_scheduler: walks a batch of words held in the input SRAM through one
// vocabulary matcher instance. Each word gets a one-cycle matcher reset, a run
// phase bounded by a timeout, and one result pushed out over valid/ready.
//
// Result handshake: res_valid rises when a result is latched and every res_*
// field stays frozen until the cycle res_valid && res_ready is seen on a rising
// clk edge; res_valid drops on the following cycle. res_valid never waits on
// res_ready, and res_ready may toggle freely while res_valid is low.
module match_scheduler #(
  parameter int ADDR_WIDTH     = 4,
  parameter int MAX_WORDS      = 8,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int CW = $clog2(MAX_WORDS + 1),
  localparam int IW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1,
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CW-1:0]         word_count,
  input  logic [ADDR_WIDTH-1:0] word_base_addr,
  input  logic [ADDR_WIDTH-1:0] word_stride,
  output logic                  m_rst_n,
  output logic                  m_cs,
  output logic [ADDR_WIDTH-1:0] m_input_start_addr,
  input  logic                  m_found,
  input  logic                  m_done,
  input  logic [ADDR_WIDTH-1:0] m_vocab_addr,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [IW-1:0]         res_word_idx,
  output logic                  res_found,
  output logic [ADDR_WIDTH-1:0] res_vocab_addr,
  output logic                  res_timeout,
  output logic [CW-1:0]         found_count,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_RUN    = 3'd2,
    S_EMIT   = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t                state;
  logic [CW-1:0]         count_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [TW-1:0]         tmr_q;
  logic [CW-1:0]         count_clamped;

  assign dbg_state = state;

  // Oversized batches are truncated to the largest supported word count.
  always_comb begin
    count_clamped = word_count;
    if (word_count > CW'(MAX_WORDS)) count_clamped = CW'(MAX_WORDS);
  end

  // Batch sequencer; every output is a register updated on state transitions
  // so that matcher controls line up exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= S_IDLE;
      count_q            <= '0;
      stride_q           <= '0;
      tmr_q              <= '0;
      m_rst_n            <= 1'b0;
      m_cs               <= 1'b0;
      m_input_start_addr <= '0;
      res_valid          <= 1'b0;
      res_word_idx       <= '0;
      res_found          <= 1'b0;
      res_vocab_addr     <= '0;
      res_timeout        <= 1'b0;
      found_count        <= '0;
      busy               <= 1'b0;
      done               <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          m_rst_n <= 1'b1;
          m_cs    <= 1'b0;
          done    <= 1'b0;
          busy    <= 1'b0;
          if (start) begin
            busy        <= 1'b1;
            found_count <= '0;
            if (word_count == '0) begin
              // Empty batch: nothing to run, just signal completion.
              done  <= 1'b1;
              state <= S_FINISH;
            end else begin
              count_q            <= count_clamped;
              stride_q           <= word_stride;
              res_word_idx       <= '0;
              m_input_start_addr <= word_base_addr;
              m_rst_n            <= 1'b0;
              state              <= S_CLEAR;
            end
          end
        end

        S_CLEAR: begin
          tmr_q   <= '0;
          m_rst_n <= 1'b1;
          m_cs    <= 1'b1;
          state   <= S_RUN;
        end

        S_RUN: begin
          tmr_q <= tmr_q + TW'(1);
          // A done on the final allowed cycle still counts as a real result.
          if (m_done) begin
            res_found      <= m_found;
            res_timeout    <= 1'b0;
            res_vocab_addr <= m_found ? m_vocab_addr : '0;
            if (m_found) found_count <= found_count + CW'(1);
            m_cs      <= 1'b0;
            res_valid <= 1'b1;
            state     <= S_EMIT;
          end else if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
            res_found      <= 1'b0;
            res_timeout    <= 1'b1;
            res_vocab_addr <= '0;
            m_cs      <= 1'b0;
            res_valid <= 1'b1;
            state     <= S_EMIT;
          end
        end

        S_EMIT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (CW'(res_word_idx) == count_q - CW'(1)) begin
              done  <= 1'b1;
              state <= S_FINISH;
            end else begin
              // Address arithmetic wraps modulo the SRAM size on purpose.
              res_word_idx       <= res_word_idx + IW'(1);
              m_input_start_addr <= m_input_start_addr + stride_q;
              m_rst_n            <= 1'b0;
              state              <= S_CLEAR;
            end
          end
        end

        S_FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_scheduler.sv
// Directed bench for match_scheduler with a behavioural matcher model that
// raises done a programmable number of run cycles after its reset.
module tb_match_scheduler;

  localparam int AW = 4;
  localparam int CW = 4;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] word_count = '0;
  logic [AW-1:0] word_base_addr = '0;
  logic [AW-1:0] word_stride = '0;
  logic          m_rst_n;
  logic          m_cs;
  logic [AW-1:0] m_input_start_addr;
  logic          m_found;
  logic          m_done;
  logic [AW-1:0] m_vocab_addr;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [IW-1:0] res_word_idx;
  logic          res_found;
  logic [AW-1:0] res_vocab_addr;
  logic          res_timeout;
  logic [CW-1:0] found_count;
  logic          busy;
  logic          done;
  logic [2:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  int n_results = 0;

  // Matcher model controls.
  int            mdl_delay = 1;
  logic          mdl_found = 1'b0;
  logic [AW-1:0] mdl_vaddr = '0;
  logic          mdl_never = 1'b0;
  int            run_cyc = 0;

  match_scheduler #(.ADDR_WIDTH(AW), .MAX_WORDS(8), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .start(start), .word_count(word_count),
    .word_base_addr(word_base_addr), .word_stride(word_stride),
    .m_rst_n(m_rst_n), .m_cs(m_cs), .m_input_start_addr(m_input_start_addr),
    .m_found(m_found), .m_done(m_done), .m_vocab_addr(m_vocab_addr),
    .res_valid(res_valid), .res_ready(res_ready), .res_word_idx(res_word_idx),
    .res_found(res_found), .res_vocab_addr(res_vocab_addr),
    .res_timeout(res_timeout), .found_count(found_count), .busy(busy),
    .done(done), .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Matcher model: counts enabled cycles since its last reset.
  always @(posedge clk) begin
    if (!m_rst_n) run_cyc <= 0;
    else if (m_cs) run_cyc <= run_cyc + 1;
  end
  assign m_done       = m_cs && m_rst_n && !mdl_never && (run_cyc == mdl_delay - 1);
  assign m_found      = mdl_found;
  assign m_vocab_addr = mdl_vaddr;

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_m_rst_n"}, m_rst_n, 0);
    chk({tag, "_m_cs"}, m_cs, 0);
    chk({tag, "_addr"}, m_input_start_addr, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_idx"}, res_word_idx, 0);
    chk({tag, "_res_found"}, res_found, 0);
    chk({tag, "_res_vaddr"}, res_vocab_addr, 0);
    chk({tag, "_res_timeout"}, res_timeout, 0);
    chk({tag, "_found_count"}, found_count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_state"}, dbg_state, 0);
  endtask

  task automatic start_batch(input logic [CW-1:0] cnt, input logic [AW-1:0] base,
                             input logic [AW-1:0] stride);
    start = 1'b1;
    word_count = cnt;
    word_base_addr = base;
    word_stride = stride;
    step();
    start = 1'b0;
  endtask

  // Called while the word is in its clear cycle; returns once the result is up.
  task automatic run_word(input int exp_d, input logic exp_found, input logic [AW-1:0] exp_vaddr,
                          input logic exp_to, input int exp_idx, input logic [AW-1:0] exp_addr);
    int n_run = 0;
    int n_clr = 0;
    int n_bad = 0;
    int guard = 0;
    chk("clear_rst_n", m_rst_n, 0);
    chk("clear_cs", m_cs, 0);
    chk("word_addr", m_input_start_addr, exp_addr);
    while (!res_valid && guard < 300) begin
      step();
      guard++;
      if (m_cs) begin
        n_run++;
        if (m_input_start_addr !== exp_addr || !m_rst_n) n_bad++;
      end
      if (!m_rst_n) n_clr++;
    end
    chk("emit_reached", res_valid, 1);
    chk("run_cycles", n_run, exp_d);
    chk("extra_clear_cycles", n_clr, 0);
    chk("run_addr_unstable", n_bad, 0);
    chk("res_idx", res_word_idx, exp_idx);
    chk("res_found", res_found, exp_found);
    chk("res_vaddr", res_vocab_addr, exp_vaddr);
    chk("res_timeout", res_timeout, exp_to);
    chk("emit_cs", m_cs, 0);
    chk("emit_busy", busy, 1);
  endtask

  task automatic accept(input int hold);
    logic [IW+AW+1:0] saved;
    saved = {res_word_idx, res_found, res_vocab_addr, res_timeout};
    res_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", res_valid, 1);
      chk("hold_stable", {res_word_idx, res_found, res_vocab_addr, res_timeout}, saved);
      chk("hold_cs", m_cs, 0);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("post_xfer_valid", res_valid, 0);
    n_results++;
  endtask

  task automatic finish_check(input int exp_fc);
    chk("finish_done", done, 1);
    chk("finish_busy", busy, 1);
    chk("finish_found_count", found_count, exp_fc);
    step();
    chk("after_done", done, 0);
    chk("after_busy", busy, 0);
    chk("after_found_count", found_count, exp_fc);
  endtask

  initial begin
    int done_seen;
    int base_results;

    // Reset and idle.
    rst = 1'b1;
    step();
    step();
    chk_reset_vals("reset");
    rst = 1'b0;
    step();
    chk("idle_m_rst_n", m_rst_n, 1);
    chk("idle_busy", busy, 0);

    // Empty batch.
    start_batch(4'd0, 4'h3, 4'h1);
    chk("zero_res_valid", res_valid, 0);
    finish_check(0);
    chk("zero_idle_valid", res_valid, 0);

    // Single word found after 6 run cycles.
    mdl_delay = 6; mdl_found = 1'b1; mdl_vaddr = 4'h5; mdl_never = 1'b0;
    start_batch(4'd1, 4'h0, 4'h0);
    chk("single_busy", busy, 1);
    run_word(6, 1'b1, 4'h5, 1'b0, 0, 4'h0);
    accept(0);
    finish_check(1);

    // Empty batch clears a non-zero found_count.
    start_batch(4'd0, 4'h0, 4'h0);
    finish_check(0);

    // Stride with wrap, backpressure on the middle word.
    mdl_delay = 2; mdl_found = 1'b1; mdl_vaddr = 4'h9;
    start_batch(4'd3, 4'hC, 4'h4);
    run_word(2, 1'b1, 4'h9, 1'b0, 0, 4'hC);
    accept(0);
    run_word(2, 1'b1, 4'h9, 1'b0, 1, 4'h0);
    accept(5);
    run_word(2, 1'b1, 4'h9, 1'b0, 2, 4'h4);
    accept(0);
    finish_check(3);

    // Matcher never finishes: timeout after exactly 64 run cycles.
    mdl_never = 1'b1; mdl_found = 1'b1; mdl_vaddr = 4'hB;
    start_batch(4'd1, 4'h2, 4'h0);
    run_word(64, 1'b0, 4'h0, 1'b1, 0, 4'h2);
    accept(0);
    finish_check(0);

    // Done on the timeout cycle wins.
    mdl_never = 1'b0; mdl_delay = 64; mdl_found = 1'b1; mdl_vaddr = 4'h7;
    start_batch(4'd1, 4'h6, 4'h0);
    run_word(64, 1'b1, 4'h7, 1'b0, 0, 4'h6);
    accept(2);
    finish_check(1);

    // Done without a match reports vocab address 0.
    mdl_delay = 3; mdl_found = 1'b0; mdl_vaddr = 4'hA;
    start_batch(4'd1, 4'h1, 4'h0);
    run_word(3, 1'b0, 4'h0, 1'b0, 0, 4'h1);
    accept(0);
    finish_check(0);

    // Oversized count clamps to 8 words.
    mdl_delay = 1; mdl_found = 1'b1; mdl_vaddr = 4'h5;
    start_batch(4'd12, 4'h1, 4'h3);
    for (int i = 0; i < 8; i++) begin
      run_word(1, 1'b1, 4'h5, 1'b0, i, 4'(1 + 3 * i));
      accept(0);
    end
    finish_check(8);

    // Reset in the middle of word 1's run.
    mdl_delay = 5; mdl_found = 1'b1; mdl_vaddr = 4'h3;
    start_batch(4'd3, 4'h2, 4'h1);
    run_word(5, 1'b1, 4'h3, 1'b0, 0, 4'h2);
    accept(0);
    step();
    step();
    chk("midrun_cs", m_cs, 1);
    rst = 1'b1;
    step();
    chk_reset_vals("midreset");
    rst = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done || res_valid || busy) done_seen++;
    end
    chk("abandoned_activity", done_seen, 0);

    // Start held high through a batch is ignored while busy.
    mdl_delay = 2; mdl_found = 1'b0; mdl_vaddr = 4'h8;
    base_results = n_results;
    start = 1'b1;
    word_count = 4'd2;
    word_base_addr = 4'h5;
    word_stride = 4'h2;
    step();
    word_count = 4'd5;
    word_base_addr = 4'h0;
    run_word(2, 1'b0, 4'h0, 1'b0, 0, 4'h5);
    accept(1);
    run_word(2, 1'b0, 4'h0, 1'b0, 1, 4'h7);
    accept(0);
    start = 1'b0;
    finish_check(0);
    chk("ignored_start_results", n_results - base_results, 2);
    step();
    chk("no_restart_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
